bus_arbiter_rr: RTL and testbench

- Round-robin arbiter for the shared 32-bit processor bus.
- Up to NUM_REQ requesters (register file, ALU, memory, IR, PC, immediate unit, ...) request the bus. The block grants exactly one of them and drives the 6-bit select of the bus source multiplexer.
- It enforces a one-cycle turnaround between owners.
- It preempts an owner that holds the bus longer than MAX_HOLD cycles while another requester is waiting.

---
 rtl/bus_arbiter_rr_pkg.sv | 16 +
 rtl/bus_arbiter_rr_if.sv | 33 +++
 rtl/rr_priority_pick.sv | 37 +++
 rtl/bus_arbiter_rr.sv | 110 +++++++++++
 tb/tb_bus_arbiter_rr.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the bus arbiter and related arbiters.
//   arb_state_t      : arbiter FSM encoding
//   BUS_SEL_WIDTH    : width of the bus source mux select
//   DEFAULT_MAX_HOLD : default ownership limit under contention
package bus_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TURN = 2'd2
    } arb_state_t;

    localparam int BUS_SEL_WIDTH    = 6;
    localparam int DEFAULT_MAX_HOLD = 16;

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the requesters and the bus arbiter.
//   req       : per-requester level request
//   done      : owner finished its transfer (single-cycle pulse)
//   grant     : one-hot grant
//   bus_sel   : index of the current owner (bus mux select)
//   bus_valid : bus has an owner this cycle
// slave modport is the arbiter side, master modport the requester side.
interface bus_arbiter_rr_if #(
    parameter int NUM_REQ   = 64,
    parameter int SEL_WIDTH = 6
);
    logic [NUM_REQ-1:0]   req;
    logic                 done;
    logic [NUM_REQ-1:0]   grant;
    logic [SEL_WIDTH-1:0] bus_sel;
    logic                 bus_valid;

    modport slave (
        input  req,
        input  done,
        output grant,
        output bus_sel,
        output bus_valid
    );

    modport master (
        output req,
        output done,
        input  grant,
        input  bus_sel,
        input  bus_valid
    );
endinterface

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: returns the lowest requesting index at or
// above ptr, otherwise the lowest requesting index below ptr.
//   req   : request vector
//   ptr   : index with highest priority
//   idx   : winning index (0 when none)
//   found : at least one request is set
module rr_priority_pick
    import bus_arbiter_rr_pkg::*;
#(
    parameter int NUM_REQ   = 64,
    parameter int SEL_WIDTH = BUS_SEL_WIDTH
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic [SEL_WIDTH-1:0] idx,
    output logic                 found
);

    // First pass finds the lowest request overall (the wrap-around winner);
    // the second pass overrides it with the lowest request at or above ptr.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = SEL_WIDTH'(i);
                found = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                idx = SEL_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared processor bus, with a one-cycle
// turnaround between owners and preemption of long holders under contention.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bus_arbiter_rr_if (req, done in; grant, bus_sel,
//           bus_valid out, all outputs registered)
//
// state   | meaning
// --------+------------------------------------------
// ST_IDLE | no owner
// ST_BUSY | bus owned by requester bus_sel
// ST_TURN | one dead cycle after a release
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int NUM_REQ   = 64,
    parameter int SEL_WIDTH = BUS_SEL_WIDTH,
    parameter int MAX_HOLD  = DEFAULT_MAX_HOLD,
    parameter int CNT_WIDTH = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    bus_arbiter_rr_if.slave bus
);

    arb_state_t           state;
    logic [NUM_REQ-1:0]   grant_q;
    logic [SEL_WIDTH-1:0] sel_q;
    logic                 valid_q;
    logic [SEL_WIDTH-1:0] ptr_q;
    logic [CNT_WIDTH-1:0] hold_cnt;

    logic [SEL_WIDTH-1:0] pick_idx;
    logic                 pick_found;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [SEL_WIDTH-1:0] ptr_next;

    logic                 others_waiting;
    logic                 owner_req;
    logic                 hold_expired;
    logic                 release_bus;

    rr_priority_pick #(
        .NUM_REQ   (NUM_REQ),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign pick_onehot = NUM_REQ'(1) << pick_idx;
    assign ptr_next    = (pick_idx == SEL_WIDTH'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    assign others_waiting = |(bus.req & ~grant_q);
    assign owner_req      = bus.req[sel_q];
    // >= rather than == so an owner whose counter already saturated while
    // uncontended is still preempted once a competitor shows up.
    assign hold_expired   = (hold_cnt >= CNT_WIDTH'(MAX_HOLD - 1));
    assign release_bus    = bus.done | ~owner_req | (hold_expired & others_waiting);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant_q  <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            ptr_q    <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_TURN: begin
                    if (pick_found) begin
                        state    <= ST_BUSY;
                        grant_q  <= pick_onehot;
                        sel_q    <= pick_idx;
                        valid_q  <= 1'b1;
                        hold_cnt <= '0;
                        ptr_q    <= ptr_next;
                    end else begin
                        state   <= ST_IDLE;
                        grant_q <= '0;
                        valid_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (release_bus) begin
                        // bus_sel is left alone so the mux stays stable.
                        state   <= ST_TURN;
                        grant_q <= '0;
                        valid_q <= 1'b0;
                    end else if (hold_cnt != CNT_WIDTH'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.bus_sel   = sel_q;
    assign bus.bus_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

    localparam int NUM_REQ   = 64;
    localparam int SEL_WIDTH = 6;
    localparam int MAX_HOLD  = 16;
    localparam int CNT_WIDTH = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;

    bus_arbiter_rr_if #(.NUM_REQ(NUM_REQ), .SEL_WIDTH(SEL_WIDTH)) bif ();

    bus_arbiter_rr #(
        .NUM_REQ   (NUM_REQ),
        .SEL_WIDTH (SEL_WIDTH),
        .MAX_HOLD  (MAX_HOLD),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Owner is an integer (-1 = none); the TURN cycle is implied by the
    // owner becoming -1 for the cycle after a release.
    int m_owner = -1;
    int m_held  = 0;   // owned cycles completed before the current one
    int m_ptr   = 0;
    int m_sel   = 0;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic bit others_waiting(input logic [NUM_REQ-1:0] r, input int o);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i != o && r[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [NUM_REQ-1:0] grant_of(input int o);
        logic [NUM_REQ-1:0] g;
        g = '0;
        if (o >= 0) g[o] = 1'b1;
        return g;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_held  <= 0;
            m_ptr   <= 0;
            m_sel   <= 0;
        end else if (m_owner >= 0) begin
            if (bif.done || !bif.req[m_owner] ||
                (m_held + 1 >= MAX_HOLD && others_waiting(bif.req, m_owner)))
                m_owner <= -1;
            else
                m_held <= m_held + 1;
        end else if (rr_pick(bif.req, m_ptr) >= 0) begin
            m_owner <= rr_pick(bif.req, m_ptr);
            m_sel   <= rr_pick(bif.req, m_ptr);
            m_held  <= 0;
            m_ptr   <= (rr_pick(bif.req, m_ptr) + 1) % NUM_REQ;
        end
    end

    always @(negedge clk) begin
        check("grant", 64'(bif.grant), 64'(grant_of(m_owner)));
        check("bus_sel", 64'(bif.bus_sel), 64'(m_sel));
        check("bus_valid", 64'(bif.bus_valid), 64'(m_owner >= 0));
        check("inv_onehot", 64'($onehot0(bif.grant)), 64'd1);
        check("inv_sel", 64'(bif.grant[bif.bus_sel]), 64'(bif.bus_valid));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [NUM_REQ-1:0] g,
                              input int sel, input logic v);
        check({name, "_grant"}, 64'(bif.grant), 64'(g));
        check({name, "_sel"}, 64'(bif.bus_sel), 64'(sel));
        check({name, "_valid"}, 64'(bif.bus_valid), 64'(v));
    endtask

    // Called just after a rising edge; returns just after the next falling edge.
    task automatic reset_pulse(input string name);
        rst_n = 1'b0;
        #1;
        expect_out(name, '0, 0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bif.req  = '0;
        bif.done = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        expect_out("rst_async", '0, 0, 1'b0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 10; i++) tick(1);
        expect_out("idle10", '0, 0, 1'b0);

        // single requester, done pulse, re-grant, drop
        bif.req = 64'd1 << 5;
        tick(1);
        expect_out("single", 64'd1 << 5, 5, 1'b1);
        tick(3);
        bif.done = 1'b1;
        tick(1);
        bif.done = 1'b0;
        expect_out("single_turn", '0, 5, 1'b0);
        tick(1);
        bif.req = '0;
        tick(2);

        reset_pulse("rst_mid1");
        tick(1);

        // round-robin with wrap
        bif.req = (64'd1 << 3) | (64'd1 << 60);
        tick(1);
        expect_out("rr3", 64'd1 << 3, 3, 1'b1);
        tick(2);
        bif.done = 1'b1;
        bif.req  = 64'd1 << 60;
        tick(1);
        bif.done = 1'b0;
        expect_out("rr_turn1", '0, 3, 1'b0);
        tick(1);
        expect_out("rr60", 64'd1 << 60, 60, 1'b1);
        bif.done = 1'b1;
        bif.req  = (64'd1 << 2) | (64'd1 << 4);
        tick(1);
        bif.done = 1'b0;
        expect_out("rr_turn2", '0, 60, 1'b0);
        tick(1);
        expect_out("rr_wrap2", 64'd1 << 2, 2, 1'b1);
        bif.done = 1'b1;
        bif.req  = 64'd1 << 4;
        tick(1);
        bif.done = 1'b0;
        tick(1);
        expect_out("rr4", 64'd1 << 4, 4, 1'b1);
        bif.done = 1'b1;
        bif.req  = '0;
        tick(1);
        bif.done = 1'b0;
        tick(1);

        // preemption of requester 1 by requester 7
        bif.req = 64'd1 << 1;
        tick(1);
        expect_out("pre_own", 64'd1 << 1, 1, 1'b1);
        tick(3);
        bif.req = bif.req | (64'd1 << 7);
        tick(12);
        expect_out("pre_16th", 64'd1 << 1, 1, 1'b1);
        tick(1);
        expect_out("pre_turn", '0, 1, 1'b0);
        tick(1);
        expect_out("pre_7", 64'd1 << 7, 7, 1'b1);
        bif.req = '0;
        tick(3);

        // no contention: owner holds indefinitely
        bif.req = 64'd1 << 1;
        tick(1);
        for (int i = 0; i < 40; i++) begin
            check("hold_alone", 64'(bif.grant), 64'd1 << 1);
            tick(1);
        end
        bif.req = '0;
        tick(1);
        expect_out("drop_req", '0, 1, 1'b0);
        tick(1);

        // reset while requester 9 owns the bus
        bif.req = 64'd1 << 9;
        tick(1);
        expect_out("own9", 64'd1 << 9, 9, 1'b1);
        bif.req = (64'd1 << 9) | 64'd1;
        reset_pulse("rst_mid2");
        tick(1);
        expect_out("post_rst0", 64'd1, 0, 1'b1);
        bif.req = '0;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
